// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, default datapath width and the
// sequencer state encoding used by the multi-cycle multiply/divide unit.
package alu_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_ST  = 5'b00001;
  localparam logic [4:0] OP_ADD = 5'b00010;
  localparam logic [4:0] OP_SUB = 5'b00011;
  localparam logic [4:0] OP_AND = 5'b00100;
  localparam logic [4:0] OP_OR  = 5'b00101;
  localparam logic [4:0] OP_XOR = 5'b00110;
  localparam logic [4:0] OP_NOT = 5'b00111;
  localparam logic [4:0] OP_SHL = 5'b01000;
  localparam logic [4:0] OP_SHR = 5'b01001;
  localparam logic [4:0] OP_SRA = 5'b01010;
  localparam logic [4:0] OP_CMP = 5'b01011;
  localparam logic [4:0] OP_MOV = 5'b01100;
  localparam logic [4:0] OP_LDI = 5'b01101;
  localparam logic [4:0] OP_NOP = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_MUL = 5'b10000;
  localparam logic [4:0] OP_BR  = 5'b10001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/addsub_w1.sv
// (W+1)-bit adder/subtractor shared by the Booth and non-restoring steps.
module addsub_w1 #(
  parameter int unsigned W = 32
) (
  input  logic [W:0] x,
  input  logic [W:0] y,
  input  logic       sub,
  output logic [W:0] s
);

  logic [W:0] y_inv;
  logic [W:0] cin;

  always_comb begin
    y_inv = y ^ {(W+1){sub}};
    cin   = {{W{1'b0}}, sub};
    s     = x + y_inv + cin;
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential signed multiply (radix-2 Booth) and divide (non-restoring on
// magnitudes), one step per cycle, result registered onto c with a done pulse.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic [4:0]           op_code,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   c,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero
);

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [WIDTH:0]       acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic                 qm1_q, qm1_d;
  logic                 is_div_q, is_div_d;
  logic                 a_neg_q, a_neg_d;
  logic                 b_neg_q, b_neg_d;
  logic [2*WIDTH-1:0]   c_q, c_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;

  logic [WIDTH:0]       add_x, add_y, add_s;
  logic                 add_sub;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH-1:0]     rem_mag, rem_fix, quo_fix;
  logic                 op_ok;

  addsub_w1 #(.W(WIDTH)) u_addsub (
    .x   (add_x),
    .y   (add_y),
    .sub (add_sub),
    .s   (add_s)
  );

  always_comb begin
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
    op_ok = (op_code == OP_MUL) || (op_code == OP_DIV);
  end

  // Adder operand steering: Booth add/sub of the multiplicand, non-restoring
  // shift-then-add/sub of the divisor, or the final remainder restore in FIX.
  always_comb begin
    add_x   = acc_q;
    add_y   = '0;
    add_sub = 1'b0;
    case (state_q)
      CALC: begin
        if (is_div_q) begin
          add_x   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
          add_y   = {1'b0, m_q};
          add_sub = ~acc_q[WIDTH];
        end else begin
          case ({q_q[0], qm1_q})
            2'b01: add_y = {m_q[WIDTH-1], m_q};
            2'b10: begin
              add_y   = {m_q[WIDTH-1], m_q};
              add_sub = 1'b1;
            end
            default: add_y = '0;
          endcase
        end
      end
      FIX: add_y = {1'b0, m_q};
      default: add_y = '0;
    endcase
  end

  always_comb begin
    rem_mag = acc_q[WIDTH] ? add_s[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix = a_neg_q ? -rem_mag : rem_mag;
    quo_fix = (a_neg_q ^ b_neg_q) ? -q_q : q_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    q_d        = q_q;
    m_d        = m_q;
    qm1_d      = qm1_q;
    is_div_d   = is_div_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    c_d        = c_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (start && op_ok) begin
          cnt_d      = '0;
          qm1_d      = 1'b0;
          div_zero_d = 1'b0;
          is_div_d   = (op_code == OP_DIV);
          a_neg_d    = a[WIDTH-1];
          b_neg_d    = b[WIDTH-1];
          if (op_code == OP_DIV) begin
            if (b == '0) begin
              // Divide by zero bypasses the datapath; DONE flags it from m_q == 0.
              acc_d   = {a[WIDTH-1], a};
              q_d     = '1;
              m_d     = '0;
              state_d = DONE;
            end else begin
              acc_d   = '0;
              q_d     = a_mag;
              m_d     = b_mag;
              state_d = CALC;
            end
          end else begin
            acc_d   = '0;
            q_d     = b;
            m_d     = a;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (is_div_q) begin
          acc_d = add_s;
          q_d   = {q_q[WIDTH-2:0], ~add_s[WIDTH]};
        end else begin
          acc_d = {add_s[WIDTH], add_s[WIDTH:1]};
          q_d   = {add_s[0], q_q[WIDTH-1:1]};
          qm1_d = q_q[0];
        end
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      FIX: begin
        if (is_div_q) begin
          acc_d = {rem_fix[WIDTH-1], rem_fix};
          q_d   = quo_fix;
        end
        state_d = DONE;
      end
      DONE: begin
        c_d        = {acc_q[WIDTH-1:0], q_q};
        done_d     = 1'b1;
        div_zero_d = is_div_q && (m_q == '0);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      m_q        <= '0;
      qm1_q      <= 1'b0;
      is_div_q   <= 1'b0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      c_q        <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      q_q        <= q_d;
      m_q        <= m_d;
      qm1_q      <= qm1_d;
      is_div_q   <= is_div_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      c_q        <= c_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    c        = c_q;
    busy     = (state_q != IDLE);
    done     = done_q;
    div_zero = div_zero_q;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a result scoreboard and a behavioural
// signed multiply/divide reference.
module tb_muldiv_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [4:0]  op_code;
  logic [31:0] a, b;
  logic [63:0] c;
  logic        busy, done, div_zero;

  typedef struct {
    logic [63:0] c;
    logic        dz;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .clear    (clear),
    .start    (start),
    .op_code  (op_code),
    .a        (a),
    .b        (b),
    .c        (c),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mul_ref(input logic [31:0] x, input logic [31:0] y);
    longint px, py, p;
    px = longint'($signed(x));
    py = longint'($signed(y));
    p  = px * py;
    return 64'(p);
  endfunction

  function automatic logic [63:0] div_ref(input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, qq, rr;
    logic [63:0] qv, rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    qq = sx / sy;
    rr = sx % sy;
    qv = 64'(qq);
    rv = 64'(rr);
    return {rv[31:0], qv[31:0]};
  endfunction

  // Drives one request through its accept edge, then scrambles the operands.
  task automatic launch(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv);
    start   = 1'b1;
    op_code = op;
    a       = av;
    b       = bv;
    tick();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] ec, input logic edz, input int eat);
    exp_t e;
    e.c  = ec;
    e.dz = edz;
    e.at = eat;
    sb.push_back(e);
    launch(op, av, bv);
  endtask

  // Waits for done, optionally pulsing start at edges p1/p2, then scores it.
  task automatic wait_done(input string tag, input int p1, input int p2);
    int   at;
    exp_t e;
    at = -1;
    for (int n = 1; n <= 80; n++) begin
      if (n == p1 || n == p2) begin
        start   = 1'b1;
        op_code = OP_MUL;
        a       = 32'h0BAD_F00D;
        b       = 32'h1234_5678;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done === 1'b1) begin
        at = n;
        break;
      end
    end
    start = 1'b0;
    if (at < 0) begin
      chk({tag, "_timeout_done"}, {63'b0, done}, 64'd1);
    end else if (sb.size() == 0) begin
      chk({tag, "_unexpected_done"}, {63'b0, done}, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_edge"}, 64'(at), 64'(e.at));
      chk({tag, "_c"}, c, e.c);
      chk({tag, "_div_zero"}, {63'b0, div_zero}, {63'b0, e.dz});
    end
  endtask

  initial begin
    int          extra_done;
    logic [31:0] ra, rb;

    clear   = 1'b1;
    start   = 1'b0;
    op_code = OP_LD;
    a       = '0;
    b       = '0;
    tick();
    start   = 1'b1;
    op_code = OP_MUL;
    a       = 32'd3;
    b       = 32'd4;
    tick();
    chk("rst_c", c, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_div_zero", {63'b0, div_zero}, 64'd0);

    clear = 1'b0;
    issue(OP_MUL, 32'd7, -32'sd3, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 34);
    chk("mul_busy_after_accept", {63'b0, busy}, 64'd1);
    wait_done("mul_7_m3", 0, 0);

    issue(OP_MUL, 32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000, 1'b0, 34);
    chk("b2b_done_dropped", {63'b0, done}, 64'd0);
    wait_done("mul_min_min", 0, 0);

    issue(OP_DIV, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 34);
    wait_done("div_100_7", 0, 0);
    issue(OP_DIV, -32'sd100, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b0, 34);
    wait_done("div_m100_7", 0, 0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 1'b0, 34);
    wait_done("div_min_m1", 0, 0);
    issue(OP_DIV, 32'd100, -32'sd7, 64'h00000002_FFFFFFF2, 1'b0, 34);
    wait_done("div_100_m7", 0, 0);

    issue(OP_DIV, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1, 1);
    wait_done("div_by_zero", 0, 0);

    start   = 1'b1;
    op_code = OP_ADD;
    a       = 32'd1;
    b       = 32'd1;
    tick();
    start = 1'b0;
    chk("badop_busy", {63'b0, busy}, 64'd0);
    chk("badop_done", {63'b0, done}, 64'd0);
    chk("badop_c_held", c, 64'h00000005_FFFFFFFF);
    chk("badop_dz_held", {63'b0, div_zero}, 64'd1);

    issue(OP_MUL, 32'd12345, -32'sd678, mul_ref(32'd12345, -32'sd678), 1'b0, 34);
    chk("dz_cleared_on_accept", {63'b0, div_zero}, 64'd0);
    wait_done("mul_busy_starts", 5, 20);
    extra_done = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (done === 1'b1) extra_done++;
    end
    chk("mul_busy_starts_single_done", 64'(extra_done), 64'd0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      issue(OP_MUL, ra, rb, mul_ref(ra, rb), 1'b0, 34);
      wait_done("mul_rand", 0, 0);
      ra = $urandom;
      rb = $urandom >> (i * 8);
      if (rb == '0) rb = 32'd3;
      if (i[0]) rb = -rb;
      issue(OP_DIV, ra, rb, div_ref(ra, rb), 1'b0, 34);
      wait_done("div_rand", 0, 0);
    end

    launch(OP_DIV, 32'd100, 32'd7);
    extra_done = 0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (done === 1'b1) extra_done++;
    end
    clear = 1'b1;
    tick();
    chk("abort_no_done_before", 64'(extra_done), 64'd0);
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_c", c, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    clear = 1'b0;
    issue(OP_MUL, 32'd7, -32'sd3, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 34);
    wait_done("mul_after_abort", 0, 0);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
